decoder_3x8_seq: RTL and testbench

Registered 3-to-8 binary-to-one-hot decoder with a valid/ready input handshake and a programmable output hold time. It is the output-side counterpart of the 8x3 octal-to-binary encoder. It drives one of eight select, strobe or LED lines from a 3-bit code, holding each line for a fixed number of cycles. An optional sweep mode walks all eight lines in order for bring-up and lamp test.

---
 rtl/decoder_3x8_seq_pkg.sv | 21 ++
 rtl/decoder_3x8_seq_onehot_dec.sv | 13 +
 rtl/decoder_3x8_seq.sv | 105 ++++++++++
 tb/tb_decoder_3x8_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_3x8_seq_pkg.sv
// Shared types and constants for the 3-to-8 sequenced decoder.
// The SWEEP state is only encoded when DEC_SWEEP_EN is defined.
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;

`ifdef DEC_SWEEP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } dec_state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_t;
`endif

endpackage

// File: rtl/decoder_3x8_seq_onehot_dec.sv
// Purely combinational CODE_W-to-LINES binary to one-hot decoder.
module onehot_dec
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LINES-1:0]  onehot
);

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    assign onehot[gi] = (code == CODE_W'(gi));
  end

endmodule

// File: rtl/decoder_3x8_seq.sv
// Registered 3-to-8 decoder with valid/ready intake and a PULSE_LEN-cycle hold.
// Defining DEC_SWEEP_EN adds sweep_start and a walk across all eight lines.
module decoder_3x8_seq
  import decoder_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] inn,
`ifdef DEC_SWEEP_EN
  input  logic              sweep_start,
`endif
  output logic [LINES-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);

  dec_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [LINES-1:0]  out_reg;
  logic              out_valid_reg;
  logic [LINES-1:0]  code_onehot;
`ifdef DEC_SWEEP_EN
  logic [CODE_W-1:0] idx_reg;
`endif

  onehot_dec u_dec (
    .code   (inn),
    .onehot (code_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
`ifdef DEC_SWEEP_EN
      idx_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef DEC_SWEEP_EN
          // A sweep request wins over a simultaneous code, which is dropped.
          if (sweep_start) begin
            state_reg     <= SWEEP;
            idx_reg       <= '0;
            out_reg       <= LINES'(1);
            out_valid_reg <= 1'b1;
            cnt_reg       <= RELOAD;
          end else
`endif
          if (in_valid) begin
            state_reg     <= HOLD;
            out_reg       <= code_onehot;
            out_valid_reg <= 1'b1;
            cnt_reg       <= RELOAD;
          end
        end
        HOLD: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
          end
        end
`ifdef DEC_SWEEP_EN
        SWEEP: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (idx_reg != CODE_W'(LINES - 1)) begin
            idx_reg <= idx_reg + 1'b1;
            out_reg <= out_reg << 1;
            cnt_reg <= RELOAD;
          end else begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg     <= IDLE;
          out_reg       <= '0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out       = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Scoreboard bench: three decoder instances (PULSE_LEN 4, 1, 2) driven with
// directed and random codes; expected outputs are queued per cycle at stimulus.
module tb_decoder_3x8_seq;

  localparam int NL = 3;
  localparam int PLS [NL] = '{4, 1, 2};
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit done [NL];

  task automatic check(input int lane, input int pl, input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL lane%0d (PULSE_LEN=%0d) %s: got %0h, expected %0h at %0t", lane, pl, nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int P = PLS[gi];

    logic       rst;
    logic       in_valid;
    logic [2:0] inn;
`ifdef DEC_SWEEP_EN
    logic       sweep_start;
`endif
    logic [7:0] out;
    logic       in_ready;
    logic       out_valid;
    logic       busy;

    decoder_3x8_seq #(.PULSE_LEN(P), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .inn         (inn),
`ifdef DEC_SWEEP_EN
      .sweep_start (sweep_start),
`endif
      .out         (out),
      .out_valid   (out_valid),
      .busy        (busy)
    );

    // Reference: a code (or sweep) occupies the block for a known number of
    // output cycles, and each of those cycles has a known one-hot value.
    logic [7:0] expq [$];
    int         rem = 0;
    bit         chk_on = 1'b0;
    logic [7:0] exp_v;

    always @(posedge clk) begin
      if (rst) begin
        rem <= 0;
        expq.delete();
      end else if (rem > 0) begin
        rem <= rem - 1;
      end
`ifdef DEC_SWEEP_EN
      else if (sweep_start) begin
        rem <= 8 * P;
        for (int l = 0; l < 8; l++)
          for (int c = 0; c < P; c++) expq.push_back(8'(1 << l));
      end
`endif
      else if (in_valid) begin
        rem <= P;
        for (int c = 0; c < P; c++) expq.push_back(8'(1 << inn));
      end
    end

    task automatic lchk(input string nm, input int act, input int exp);
      check(gi, P, nm, act, exp);
    endtask

    always @(negedge clk) begin
      if (chk_on) begin
        lchk("in_ready", int'(in_ready), int'(rem == 0));
        lchk("busy", int'(busy), int'(rem != 0));
        lchk("out_valid", int'(out_valid), int'(rem != 0));
        if (out_valid) begin
          if (expq.size() == 0) begin
            lchk("unexpected_out", int'(out), 0);
          end else begin
            exp_v = expq.pop_front();
            lchk("out", int'(out), int'(exp_v));
          end
        end else begin
          lchk("out_idle", int'(out), 0);
        end
      end
    end

    task automatic send(input logic [2:0] c, input bit keep);
      int n = 0;
      in_valid = 1'b1;
      inn = c;
      while (!in_ready && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      if (n >= LIMIT) lchk("accept_timeout", n, 0);
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int n = 0;
      while (rem != 0 && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      if (n >= LIMIT) lchk("idle_timeout", n, 0);
    endtask

    task automatic reset_pulse();
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lchk("rst_out", int'(out), 0);
      lchk("rst_in_ready", int'(in_ready), 1);
      lchk("rst_busy", int'(busy), 0);
    endtask

    initial begin
      int n;
      rst = 1'b1;
      in_valid = 1'b0;
      inn = '0;
`ifdef DEC_SWEEP_EN
      sweep_start = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk_on = 1'b1;
      rst = 1'b0;
      lchk("reset_out", int'(out), 0);
      lchk("reset_out_valid", int'(out_valid), 0);
      lchk("reset_in_ready", int'(in_ready), 1);
      lchk("reset_busy", int'(busy), 0);

      // Single code, then back-to-back with in_valid held high.
      send(3'd5, 1'b0);
      wait_idle();
      send(3'd0, 1'b1);
      send(3'd7, 1'b1);
      send(3'd2, 1'b0);
      wait_idle();

      // Reset on the second HOLD cycle abandons the code.
      send(3'd6, 1'b0);
      @(negedge clk);
      reset_pulse();

      for (int c = 0; c < 8; c++) begin
        send(3'(c), 1'b0);
        wait_idle();
      end

`ifdef DEC_SWEEP_EN
      wait_idle();
      sweep_start = 1'b1;
      in_valid = 1'b1;
      inn = 3'd3;
      @(negedge clk);
      sweep_start = 1'b0;
      in_valid = 1'b0;
      n = 0;
      while (busy && n < LIMIT) begin
        n++;
        @(negedge clk);
      end
      lchk("sweep_busy_len", n, 8 * P);
`endif

      for (int it = 0; it < 60; it++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          reset_pulse();
        end
`ifdef DEC_SWEEP_EN
        else if (r == 1) begin
          wait_idle();
          sweep_start = 1'b1;
          in_valid = 1'($urandom_range(0, 1));
          inn = 3'($urandom);
          @(negedge clk);
          sweep_start = 1'b0;
          in_valid = 1'b0;
        end
`endif
        else begin
          send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      in_valid = 1'b0;
      wait_idle();
      @(negedge clk);
      lchk("queue_empty", expq.size(), 0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < NL; i++) wait (done[i]);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
